// File: rtl/rr_priority_arbiter_if.sv
// rtl/rr_priority_arbiter_if.sv - request/grant bundle between requesters and the round-robin arbiter
interface rr_priority_arbiter_if #(
   parameter int N     = 8,
   parameter int IDX_W = 3
);
   logic [N-1:0]     req;
   logic [N-1:0]     gnt;
   logic [IDX_W-1:0] gnt_idx;
   logic             gnt_valid;
   logic             preempt;

   modport master (output req, input gnt, gnt_idx, gnt_valid, preempt);
   modport slave  (input req, output gnt, gnt_idx, gnt_valid, preempt);
endinterface

// File: rtl/rr_priority_arbiter.sv
// rtl/rr_priority_arbiter.sv - round-robin arbiter with registered grant, hold and MAX_HOLD preemption
module rr_priority_arbiter #(
   parameter int N        = 8,
   parameter int IDX_W    = 3,
   parameter int MAX_HOLD = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   rr_priority_arbiter_if.slave  bus
);
   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] GRANT = 1'b1;

   localparam int              HC_W   = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
   localparam logic [HC_W-1:0] HC_SAT = HC_W'((MAX_HOLD == 0) ? 1 : MAX_HOLD);
   localparam logic [HC_W-1:0] HC_PRE = HC_W'(MAX_HOLD);

   logic [0:0]       state;
   logic [IDX_W-1:0] ptr;
   logic [IDX_W-1:0] next_ptr;
   logic [IDX_W-1:0] h_next;
   logic [HC_W-1:0]  hold_cnt;
   logic [N-1:0]     cand;
   logic             release_c;
   logic             preempt_c;
   logic [IDX_W:0]   pick_r;
   logic             win_found;
   logic [IDX_W-1:0] win_idx;

   // Scan descending so the candidate closest to start is the last (winning) assignment.
   function automatic logic [IDX_W:0] pick(input logic [N-1:0] c, input logic [IDX_W-1:0] start);
      logic [IDX_W:0] r;
      r = '0;
      for (int i = N - 1; i >= 0; i--) begin
         int k;
         k = (int'(start) + i) % N;
         if (c[k]) r = {1'b1, IDX_W'(k)};
      end
      return r;
   endfunction

   always_comb begin
      release_c = (state == GRANT) && !bus.req[bus.gnt_idx];
      preempt_c = (state == GRANT) && !release_c && (MAX_HOLD != 0) &&
                  (hold_cnt == HC_PRE) && (|(bus.req & ~bus.gnt));
      h_next    = (bus.gnt_idx == IDX_W'(N - 1)) ? '0 : bus.gnt_idx + 1'b1;
      next_ptr  = (release_c || preempt_c) ? h_next : ptr;
      cand      = preempt_c ? (bus.req & ~bus.gnt) : bus.req;
      pick_r    = pick(cand, next_ptr);
      win_found = pick_r[IDX_W];
      win_idx   = pick_r[IDX_W-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         ptr           <= '0;
         hold_cnt      <= '0;
         bus.gnt       <= '0;
         bus.gnt_idx   <= '0;
         bus.gnt_valid <= 1'b0;
         bus.preempt   <= 1'b0;
      end else begin
         bus.preempt <= 1'b0;
         if (release_c || preempt_c) ptr <= next_ptr;
         case (state)
            IDLE: begin
               if (win_found) begin
                  bus.gnt       <= {{(N-1){1'b0}}, 1'b1} << win_idx;
                  bus.gnt_idx   <= win_idx;
                  bus.gnt_valid <= 1'b1;
                  hold_cnt      <= HC_W'(1);
                  state         <= GRANT;
               end
            end
            GRANT: begin
               if (release_c || preempt_c) begin
                  if (win_found) begin
                     bus.gnt     <= {{(N-1){1'b0}}, 1'b1} << win_idx;
                     bus.gnt_idx <= win_idx;
                     bus.preempt <= preempt_c;
                     hold_cnt    <= HC_W'(1);
                  end else begin
                     // gnt_idx deliberately keeps the last holder.
                     bus.gnt       <= '0;
                     bus.gnt_valid <= 1'b0;
                     state         <= IDLE;
                  end
               end else if (hold_cnt < HC_SAT) begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_rr_priority_arbiter.sv
// tb/tb_rr_priority_arbiter.sv - bench for rr_priority_arbiter against a rule-level reference model
module tb_rr_priority_arbiter;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] req = 8'hFF;
   int         checks = 0;
   int         errors = 0;

   always #5 clk = ~clk;

   rr_priority_arbiter_if #(.N(8), .IDX_W(3)) b0 ();
   rr_priority_arbiter_if #(.N(8), .IDX_W(3)) b1 ();
   assign b0.req = req;
   assign b1.req = req;

   rr_priority_arbiter #(.N(8), .IDX_W(3), .MAX_HOLD(4))  dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
   rr_priority_arbiter #(.N(8), .IDX_W(3), .MAX_HOLD(16)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

   // Reference state per instance: holder = -1 means nobody is granted.
   int maxh [2] = '{4, 16};
   int m_hold [2];
   int m_gidx [2];
   int m_ptr  [2];
   int m_cnt  [2];
   int m_pre  [2];
   int pre_count;

   function automatic int scan(input logic [7:0] c, input int p);
      for (int k = 0; k < 8; k++)
         if (c[(p + k) % 8]) return (p + k) % 8;
      return -1;
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_hold[d] = -1; m_gidx[d] = 0; m_ptr[d] = 0; m_cnt[d] = 0; m_pre[d] = 0;
      end
   endtask

   task automatic model_edge(input int d, input logic [7:0] r);
      int h;
      int w;
      logic [7:0] others;
      m_pre[d] = 0;
      h = m_hold[d];
      if (h < 0) begin
         if (r != 0) begin
            w = scan(r, m_ptr[d]);
            m_hold[d] = w; m_gidx[d] = w; m_cnt[d] = 1;
         end
      end else begin
         others = r;
         others[h] = 1'b0;
         if (!r[h]) begin
            m_ptr[d] = (h + 1) % 8;
            if (r != 0) begin
               w = scan(r, m_ptr[d]);
               m_hold[d] = w; m_gidx[d] = w; m_cnt[d] = 1;
            end else begin
               m_hold[d] = -1;
            end
         end else if (maxh[d] != 0 && m_cnt[d] == maxh[d] && others != 0) begin
            m_ptr[d] = (h + 1) % 8;
            w = scan(others, m_ptr[d]);
            m_hold[d] = w; m_gidx[d] = w; m_cnt[d] = 1; m_pre[d] = 1;
         end else if (m_cnt[d] < maxh[d]) begin
            m_cnt[d]++;
         end
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      logic [7:0] eg;
      for (int d = 0; d < 2; d++) begin
         eg = '0;
         if (m_hold[d] >= 0) eg[m_hold[d]] = 1'b1;
         if (d == 0) begin
            chk("gnt0", 32'(b0.gnt), 32'(eg));
            chk("gnt_idx0", 32'(b0.gnt_idx), 32'(m_gidx[d]));
            chk("gnt_valid0", 32'(b0.gnt_valid), 32'(m_hold[d] >= 0));
            chk("preempt0", 32'(b0.preempt), 32'(m_pre[d]));
         end else begin
            chk("gnt1", 32'(b1.gnt), 32'(eg));
            chk("gnt_idx1", 32'(b1.gnt_idx), 32'(m_gidx[d]));
            chk("gnt_valid1", 32'(b1.gnt_valid), 32'(m_hold[d] >= 0));
            chk("preempt1", 32'(b1.preempt), 32'(m_pre[d]));
         end
      end
   endtask

   // Drive req, take one edge, advance the model, sample 1ns later.
   task automatic cycle(input logic [7:0] r);
      req = r;
      @(posedge clk);
      model_edge(0, r);
      model_edge(1, r);
      #1;
      check_all();
   endtask

   // Asynchronous reset asserted mid-cycle, released on a falling edge.
   task automatic async_reset();
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      logic [7:0] r;
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1;
      check_all();
      chk("reset_gnt", 32'(b0.gnt), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) cycle(8'h00);

      cycle(8'b0000_0100);
      chk("latency_idx", 32'(b0.gnt_idx), 32'd2);
      chk("latency_gnt", 32'(b0.gnt), 32'h04);
      cycle(8'b0000_0000);
      chk("release_idx_kept", 32'(b0.gnt_idx), 32'd2);
      chk("release_valid", 32'(b0.gnt_valid), 32'd0);

      cycle(8'b0000_0110);
      chk("b2b_first", 32'(b0.gnt_idx), 32'd1);
      cycle(8'b0000_0100);
      chk("b2b_second", 32'(b0.gnt_idx), 32'd2);
      chk("b2b_valid", 32'(b0.gnt_valid), 32'd1);
      chk("b2b_no_preempt", 32'(b0.preempt), 32'd0);

      async_reset();
      pre_count = 0;
      for (int i = 0; i < 33; i++) begin
         cycle(8'hFF);
         if (b0.preempt) pre_count++;
      end
      chk("rr_preempt_count", 32'(pre_count), 32'd8);
      chk("rr_wrap_idx", 32'(b0.gnt_idx), 32'd0);

      async_reset();
      cycle(8'b1000_0000);
      chk("wrap_holder", 32'(b0.gnt_idx), 32'd7);
      cycle(8'b0000_0001);
      chk("wrap_to_0", 32'(b0.gnt_idx), 32'd0);
      pre_count = 0;
      for (int i = 0; i < 40; i++) begin
         cycle(8'b0000_0001);
         if (b1.preempt) pre_count++;
      end
      chk("lone_holder_idx", 32'(b1.gnt_idx), 32'd0);
      chk("lone_no_preempt", 32'(pre_count), 32'd0);

      async_reset();
      cycle(8'b0010_0000);
      cycle(8'b0010_0000);
      chk("mid_grant_idx", 32'(b0.gnt_idx), 32'd5);
      async_reset();
      chk("mid_reset_valid", 32'(b0.gnt_valid), 32'd0);
      cycle(8'b0010_0001);
      chk("post_reset_idx", 32'(b0.gnt_idx), 32'd0);

      r = 8'h00;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 3) == 0) r = 8'($urandom);
         else if ($urandom_range(0, 5) == 0) r[$urandom_range(0, 7)] = 1'b0;
         cycle(r);
         if ($urandom_range(0, 99) == 0) async_reset();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
